// File: rtl/serial_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_rx_pkg                                                        |
// | Shared types and constants for the triplicated serial receiver.      |
// | Contents: state_t (IDLE/SHIFT/HOLD), DEFAULT_WIDTH, count_width().   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    HOLD  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 128;

  // Counter must be able to represent 0..WIDTH inclusive.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_rx_core                                                       |
// | One receiver copy: FSM, bit counter, shift register, sticky flags.   |
// | Inputs : clk, rst, serial_in, serial_valid, start, msb_first,        |
// |          out_ready, clr_err                                          |
// | Outputs: state, count, data, dir, overrun, frame_err (raw state,     |
// |          voted and compared by the parent)                           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module serial_rx_core
  import serial_rx_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             start,
  input  logic             msb_first,
  input  logic             out_ready,
  input  logic             clr_err,
  output state_t           state,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] data,
  output logic             dir,
  output logic             overrun,
  output logic             frame_err
);

  logic          take;
  logic [CW-1:0] count_inc;
  logic          last;

  assign take      = serial_valid & start;
  assign count_inc = count + 1'b1;
  assign last      = (count_inc == CW'(WIDTH));

  // LSB-first enters at the top and moves right; MSB-first enters at bit 0
  // and moves left, so the first bit ends up at data[0] / data[WIDTH-1].
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic b,
                                                input logic msb);
    if (msb) return {cur[WIDTH-2:0], b};
    else     return {b, cur[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      data      <= '0;
      dir       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Clear first so a same-cycle set below takes priority.
      if (clr_err) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (take) begin
            data  <= shift_in(data, serial_in, msb_first);
            count <= CW'(1);
            dir   <= msb_first;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (take) begin
            data      <= shift_in(data, serial_in, msb_first);
            count     <= CW'(1);
            dir       <= msb_first;
            frame_err <= 1'b1;
          end else if (serial_valid) begin
            data <= shift_in(data, serial_in, dir);
            if (last) begin
              count <= '0;
              state <= HOLD;
            end else begin
              count <= count_inc;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            // Word is released this cycle; a coincident start opens the next frame.
            if (take) begin
              data  <= shift_in(data, serial_in, msb_first);
              count <= CW'(1);
              dir   <= msb_first;
              state <= SHIFT;
            end else begin
              state <= IDLE;
            end
          end else if (take) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/serial_receiver_tmr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_receiver_tmr                                                  |
// | Triple-modular-redundant serial-to-parallel receiver.                |
// | Inputs : clk, rst, serial_in, serial_valid, start, msb_first,        |
// |          out_ready, clr_err                                          |
// | Outputs: parallel_out, out_valid, busy, overrun, frame_err (2-of-3   |
// |          voted), mismatch (any copy disagrees on any state bit)      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module serial_receiver_tmr
  import serial_rx_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CW    = count_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             serial_valid,
  input  logic             start,
  input  logic             msb_first,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  output logic             mismatch
);

  localparam int SW = 2 + CW + WIDTH + 3;

  state_t           st   [3];
  logic [CW-1:0]    cnt  [3];
  logic [WIDTH-1:0] dat  [3];
  logic             dir  [3];
  logic             ovr  [3];
  logic             ferr [3];
  logic [SW-1:0]    snap [3];
  logic             hold_q  [3];
  logic             shift_q [3];

  serial_rx_core #(.WIDTH(WIDTH)) u_core0 (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .start(start), .msb_first(msb_first), .out_ready(out_ready), .clr_err(clr_err),
    .state(st[0]), .count(cnt[0]), .data(dat[0]), .dir(dir[0]),
    .overrun(ovr[0]), .frame_err(ferr[0])
  );

  serial_rx_core #(.WIDTH(WIDTH)) u_core1 (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .start(start), .msb_first(msb_first), .out_ready(out_ready), .clr_err(clr_err),
    .state(st[1]), .count(cnt[1]), .data(dat[1]), .dir(dir[1]),
    .overrun(ovr[1]), .frame_err(ferr[1])
  );

  serial_rx_core #(.WIDTH(WIDTH)) u_core2 (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .start(start), .msb_first(msb_first), .out_ready(out_ready), .clr_err(clr_err),
    .state(st[2]), .count(cnt[2]), .data(dat[2]), .dir(dir[2]),
    .overrun(ovr[2]), .frame_err(ferr[2])
  );

  function automatic logic [WIDTH-1:0] vote_w(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic vote1(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Per-copy decoded status and a flat snapshot of every state bit.
  for (genvar i = 0; i < 3; i++) begin : g_copy
    assign hold_q[i]  = (st[i] == HOLD);
    assign shift_q[i] = (st[i] == SHIFT);
    assign snap[i]    = {st[i], cnt[i], dat[i], dir[i], ovr[i], ferr[i]};
  end

  assign parallel_out = vote_w(dat[0], dat[1], dat[2]);
  assign out_valid    = vote1(hold_q[0],  hold_q[1],  hold_q[2]);
  assign busy         = vote1(shift_q[0], shift_q[1], shift_q[2]);
  assign overrun      = vote1(ovr[0],  ovr[1],  ovr[2]);
  assign frame_err    = vote1(ferr[0], ferr[1], ferr[2]);

  assign mismatch = (snap[0] != snap[1]) | (snap[1] != snap[2]) | (snap[0] != snap[2]);

endmodule
`default_nettype wire

// File: tb/tb_serial_receiver_tmr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_receiver_tmr                                               |
// | Directed self-checking bench for serial_receiver_tmr (WIDTH=128).    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_serial_receiver_tmr;

  localparam logic [127:0] FRAME   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] FLIPPED = FRAME ^ 128'h20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         serial_in = 1'b0;
  logic         serial_valid = 1'b0;
  logic         start = 1'b0;
  logic         msb_first = 1'b0;
  logic         out_ready = 1'b0;
  logic         clr_err = 1'b0;
  logic [127:0] parallel_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;
  logic         frame_err;
  logic         mismatch;

  logic [127:0] frame_v;
  int checks = 0;
  int errors = 0;

  serial_receiver_tmr #(.WIDTH(128)) u_dut (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .start(start), .msb_first(msb_first), .out_ready(out_ready), .clr_err(clr_err),
    .parallel_out(parallel_out), .out_valid(out_valid), .busy(busy),
    .overrun(overrun), .frame_err(frame_err), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic st, input logic msb);
    serial_in    = b;
    serial_valid = 1'b1;
    start        = st;
    msb_first    = msb;
    tick();
    serial_valid = 1'b0;
    start        = 1'b0;
  endtask

  // Sends frame positions lo..hi-1; position k carries v[k] (LSB) or v[127-k] (MSB).
  task automatic send_range(input logic [127:0] v, input logic msb, input int lo,
                            input int hi, input logic first_start);
    for (int k = lo; k < hi; k++) begin
      send_bit(msb ? v[127-k] : v[k], first_start && (k == lo), msb);
    end
  endtask

  task automatic release_word();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++; if (parallel_out !== 128'd0) begin errors++; $display("FAIL reset_data got %h want 0", parallel_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %b want 0", mismatch); end
  endtask

  task automatic test_lsb_frame();
    send_range(frame_v, 1'b0, 0, 127, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lsb_busy_mid got %b want 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lsb_valid_early got %b want 0", out_valid); end
    send_range(frame_v, 1'b0, 127, 128, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid got %b want 1", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lsb_busy_end got %b want 0", busy); end
    checks++; if (parallel_out !== FRAME) begin errors++; $display("FAIL lsb_word got %h want %h", parallel_out, FRAME); end
    // Bits without start while holding are ignored.
    repeat (3) send_bit(1'b1, 1'b0, 1'b0);
    checks++; if (parallel_out !== FRAME) begin errors++; $display("FAIL hold_stable_word got %h want %h", parallel_out, FRAME); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_stable_valid got %b want 1", out_valid); end
    release_word();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_valid got %b want 0", out_valid); end
    // Bits without start in IDLE are ignored.
    repeat (2) send_bit(1'b1, 1'b0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_ignore_busy got %b want 0", busy); end
  endtask

  task automatic test_msb_gaps();
    int n;
    n = 0;
    for (int k = 0; k < 128; k++) begin
      send_bit(frame_v[127-k], k == 0, 1'b1);
      n++;
      if ((k % 5 == 2) && (k < 127)) begin
        repeat (2) tick();
        checks++; if (u_dut.u_core0.count !== 8'(n)) begin errors++; $display("FAIL msb_gap_count got %0d want %0d", u_dut.u_core0.count, n); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL msb_valid got %b want 1", out_valid); end
    checks++; if (parallel_out !== FRAME) begin errors++; $display("FAIL msb_word got %h want %h", parallel_out, FRAME); end
    release_word();
  endtask

  task automatic test_overrun();
    send_range(frame_v, 1'b0, 0, 128, 1'b1);
    send_bit(1'b0, 1'b1, 1'b0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
    checks++; if (parallel_out !== FRAME) begin errors++; $display("FAIL overrun_word got %h want %h", parallel_out, FRAME); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got %b want 1", out_valid); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got %b want 0", overrun); end
    // A set in the same cycle as clear wins.
    clr_err = 1'b1;
    send_bit(1'b0, 1'b1, 1'b0);
    clr_err = 1'b0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins got %b want 1", overrun); end
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    release_word();
  endtask

  task automatic test_back_to_back();
    send_range(frame_v, 1'b0, 0, 128, 1'b1);
    out_ready = 1'b1;
    send_bit(frame_v[0], 1'b1, 1'b0);
    out_ready = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %b want 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", overrun); end
    checks++; if (u_dut.u_core0.count !== 8'd1) begin errors++; $display("FAIL b2b_count got %0d want 1", u_dut.u_core0.count); end
    send_range(frame_v, 1'b0, 1, 128, 1'b0);
    checks++; if (parallel_out !== FRAME) begin errors++; $display("FAIL b2b_word got %h want %h", parallel_out, FRAME); end
    release_word();
  endtask

  task automatic test_frame_err();
    logic [127:0] alt;
    alt = ~frame_v;
    send_range(alt, 1'b0, 0, 60, 1'b1);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_before got %b want 0", frame_err); end
    send_range(frame_v, 1'b0, 0, 1, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_set got %b want 1", frame_err); end
    send_range(frame_v, 1'b0, 1, 128, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ferr_valid got %b want 1", out_valid); end
    checks++; if (parallel_out !== FRAME) begin errors++; $display("FAIL ferr_word got %h want %h", parallel_out, FRAME); end
    release_word();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_clr got %b want 0", frame_err); end
  endtask

  task automatic test_tmr();
    send_range(frame_v, 1'b0, 0, 128, 1'b1);
    force u_dut.u_core0.data = FLIPPED;
    #1;
    checks++; if (parallel_out !== FRAME) begin errors++; $display("FAIL tmr_word got %h want %h", parallel_out, FRAME); end
    checks++; if (mismatch !== 1'b1) begin errors++; $display("FAIL tmr_mismatch got %b want 1", mismatch); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tmr_valid got %b want 1", out_valid); end
    release u_dut.u_core0.data;
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL tmr_rst_mismatch got %b want 0", mismatch); end
  endtask

  task automatic test_reset_midframe();
    send_range(frame_v, 1'b0, 0, 40, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
    rst = 1'b1;
    send_bit(frame_v[40], 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (parallel_out !== 128'd0) begin errors++; $display("FAIL mid_data got %h want 0", parallel_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_rst got %b want 0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", out_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_ferr got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun got %b want 0", overrun); end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL mid_mismatch got %b want 0", mismatch); end
  endtask

  initial begin
    frame_v = FRAME;
    test_reset();
    test_lsb_frame();
    test_msb_gaps();
    test_overrun();
    test_back_to_back();
    test_frame_err();
    test_tmr();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
